// File: rtl/cpu_sequencer.sv
// Instruction sequencer: issues ROM or switch instructions to the datapath via IDLE/FETCH/EXEC/WB.
// Optional single-step gating of ROM issue with `define CPU_SEQUENCER_SINGLE_STEP_EN (adds port step).
module cpu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       rom_inst,
  input  logic             rom_done,
  input  logic [7:0]       ext_inst,
  input  logic             ext_go,
  input  logic             mode,
  input  logic             cpu_ack,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             inst_done,
  output logic [7:0]       cpu_inst,
  output logic             cpu_valid,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] exec_count
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

  state_t state, state_nxt;
  logic   src, src_nxt;
  logic   rom_go;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  assign rom_go = ~rom_done & step;
`else
  assign rom_go = ~rom_done;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      src        <= 1'b0;
      cpu_inst   <= 8'h00;
      exec_count <= '0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      if (state == FETCH)
        cpu_inst <= src ? ext_inst : rom_inst;
      // Saturating retire counter: holds at all-ones.
      if (state == WB && exec_count != {CNT_W{1'b1}})
        exec_count <= exec_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    cpu_valid = 1'b0;
    inst_done = 1'b0;
    busy      = 1'b1;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!mode) begin
          if (rom_done) begin
            state_nxt = HALT;
          end else if (rom_go) begin
            state_nxt = FETCH;
            src_nxt   = 1'b0;
          end
        end else if (ext_go) begin
          state_nxt = FETCH;
          src_nxt   = 1'b1;
        end
      end
      FETCH: state_nxt = EXEC;
      EXEC: begin
        cpu_valid = 1'b1;
        if (cpu_ack)
          state_nxt = WB;
      end
      WB: begin
        // Only ROM-sourced instructions advance the ROM PC.
        inst_done = ~src;
        state_nxt = IDLE;
      end
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (mode)
          state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
